pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Sequences the multi-output core PLL on the 50 MHz reference clock and owns the PLL reset pin. The block pulses the PLL reset, waits for lock with a timeout and retry, and qualifies lock for a stable window. Only then does it release the core-wide synchronous reset. On lock loss or a software restart request it drops the core back into reset and re-runs the sequence.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per attempt (minimum 2)
LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (1 ms at 50 MHz)
STABLE_CYCLES, 1024, cycles lock must stay continuously high before release
RETRY_MAX, 7, failed attempts before FAIL (used only with PLL_RETRY_LIMIT_EN)

Ports:
refclk  in  1  free-running reference clock, sole clock of the block
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock indicator, asynchronous to refclk
req_restart  in  1  single-cycle request to re-run the PLL sequence
pll_rst  out  1  reset to PLL, active high
sys_rst  out  1  core synchronous reset, active high
ready  out  1  high only in RUN
retry_cnt  out  8  lock-timeout/lock-loss count, saturating
state  out  3  current state encoding, for debug
fail  out  1  retry limit exhausted

Behaviour:
- pll_locked passes through a 2-flop synchronizer (flops reset to 0), giving lock_s with 2-cycle latency. No other input is synchronized.
- State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. One shared down/up counter, cleared on every state change.
- Every output is a registered decode of next-state, so outputs change on the same edge as state.
- On rst: state=RESET, counter=0, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, fail=0, synchronizer=0. rst mid-sequence aborts immediately to this condition.
- RESET: pll_rst=1. After RST_CYCLES cycles in the state, go to WAIT_LOCK. req_restart is ignored here.
- WAIT_LOCK: pll_rst=0.
  - lock_s=1 goes to STABLE.
  - If the counter reaches LOCK_TIMEOUT-1 with no lock, go to RESET and increment retry_cnt.
- STABLE: pll_rst=0.
  - lock_s=0 goes to WAIT_LOCK, with no retry increment and the timeout restarted.
  - If the counter reaches STABLE_CYCLES-1 with lock held, go to RUN.
- RUN: sys_rst=0, ready=1. lock_s=0 goes to RESET and increments retry_cnt.
- req_restart in WAIT_LOCK, STABLE or RUN goes to RESET without incrementing retry_cnt. If it coincides with lock loss in RUN, lock loss wins and retry_cnt increments.
- sys_rst=1 and ready=0 in every state except RUN.
- retry_cnt saturates at 255 and clears only on rst. This applies whenever PLL_RETRY_LIMIT_EN is undefined; with the macro, req_restart out of FAIL also clears it (see below).
- Worst-case response to lock loss in RUN: sys_rst asserted 3 refclk edges after pll_locked falls.

Optional Feature:
Macro PLL_RETRY_LIMIT_EN.
- Defined:
  - When an increment would make retry_cnt equal RETRY_MAX, the transition goes to FAIL instead of RESET.
  - FAIL: pll_rst=1, sys_rst=1, ready=0, fail=1.
  - Only rst or req_restart leave FAIL. Both go to RESET and clear retry_cnt and fail.
- Undefined:
  - The FAIL state and the RETRY_MAX comparator are not built, and fail is tied 0.
  - Retries continue indefinitely, with retry_cnt saturating at 255.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8 unless stated.
1. Release rst with pll_locked held 1 -> pll_rst high for cycles 0-3, STABLE entered at cycle 5, sys_rst falls and ready rises at cycle 13; retry_cnt=0.
2. pll_locked held 0 for 300 cycles, macro undefined -> pll_rst re-pulses every 24 cycles; retry_cnt=12 at cycle 300; fail=0.
3. pll_locked drops for 1 cycle at STABLE count 5 -> back to WAIT_LOCK, then STABLE re-entered; ready rises 8+ cycles after re-lock; retry_cnt unchanged.
4. In RUN, pll_locked falls -> sys_rst=1 and state=RESET on the 3rd edge after the fall; retry_cnt +1; normal re-lock returns to RUN.
5. req_restart pulse in RUN -> RESET next edge, retry_cnt unchanged. Same pulse coincident with lock_s=0 -> retry_cnt +1.
6. Macro defined, RETRY_MAX=3, pll_locked held 0 -> FAIL after 3rd timeout (cycle 72), fail=1, pll_rst=1 held. req_restart -> RESET with retry_cnt=0 and fail=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on refclk; releases sys_rst once lock is stable.
// Define PLL_RETRY_LIMIT_EN to add the FAIL state after RETRY_MAX failures.
module pll_reset_sequencer #(
`ifdef PLL_RETRY_LIMIT_EN
  parameter int RETRY_MAX     = 7,
`endif
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       req_restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [2:0] state,
  output logic       fail
);

  localparam int MAX_AB =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
`ifdef PLL_RETRY_LIMIT_EN
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
`else
    S_RUN    = 3'd3
`endif
  } st_t;

  st_t           st_q;
  st_t           st_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          bump;
  logic          clr_retry;
  logic [7:0]    retry_d;

  assign lock_s = sync_q[1];
  assign state  = st_q;

  always_comb begin
    st_d      = st_q;
    bump      = 1'b0;
    clr_retry = 1'b0;
    case (st_q)
      S_RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1))
          st_d = S_WAIT;
      end
      S_WAIT: begin
        if (req_restart) begin
          st_d = S_RESET;
        end else if (lock_s) begin
          st_d = S_STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          st_d = S_RESET;
          bump = 1'b1;
        end
      end
      S_STABLE: begin
        if (req_restart)
          st_d = S_RESET;
        else if (!lock_s)
          st_d = S_WAIT;
        else if (cnt_q == CW'(STABLE_CYCLES - 1))
          st_d = S_RUN;
      end
      // lock loss outranks a coincident restart request
      S_RUN: begin
        if (!lock_s) begin
          st_d = S_RESET;
          bump = 1'b1;
        end else if (req_restart) begin
          st_d = S_RESET;
        end
      end
`ifdef PLL_RETRY_LIMIT_EN
      S_FAIL: begin
        if (req_restart) begin
          st_d      = S_RESET;
          clr_retry = 1'b1;
        end
      end
`endif
      default: st_d = S_RESET;
    endcase

    retry_d = retry_cnt;
    if (clr_retry)
      retry_d = 8'd0;
    else if (bump && retry_cnt != 8'hff)
      retry_d = retry_cnt + 8'd1;

`ifdef PLL_RETRY_LIMIT_EN
    if (bump && retry_d == 8'(RETRY_MAX))
      st_d = S_FAIL;
`endif
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      st_q      <= S_RESET;
      cnt_q     <= '0;
      sync_q    <= 2'b00;
      retry_cnt <= 8'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
    end else begin
      st_q      <= st_d;
      sync_q    <= {sync_q[0], pll_locked};
      retry_cnt <= retry_d;
      if (st_d != st_q)
        cnt_q <= '0;
      else if (st_q != S_RUN)
        cnt_q <= cnt_q + CW'(1);
`ifdef PLL_RETRY_LIMIT_EN
      pll_rst <= (st_d == S_RESET) || (st_d == S_FAIL);
`else
      pll_rst <= (st_d == S_RESET);
`endif
      sys_rst <= (st_d != S_RUN);
      ready   <= (st_d == S_RUN);
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  always_ff @(posedge refclk) begin
    if (rst)
      fail <= 1'b0;
    else
      fail <= (st_d == S_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

endmodule
